id_branch_resolver: RTL and testbench

Parametrised ID-stage branch resolution unit, successor to the single-mode BEQ/BNE decode logic. It resolves BEQ, BNE, BLEZ and BGTZ in ID. Operands are forwarded from EX/MEM and MEM/WB. A small stall FSM inserts 1 or 2 bubbles for ALU-use and load-use hazards on branch operands. The redirect (taken flag + target) is registered, and branch/taken statistics counters are kept. It sits between the register file read ports and the IF-stage PC mux.

---
 rtl/id_branch_resolver_if.sv | 60 ++++++
 rtl/id_branch_resolver.sv | 157 +++++++++++++++
 tb/tb_id_branch_resolver.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/id_branch_resolver_if.sv
// Bundle of the ID-stage branch resolver's pipeline-facing signals.
// The master drives the ID-stage operands and the EX/MEM/WB pipeline state,
// and receives the stall, flush, redirect and statistics outputs.
// The slave is the resolver's side of the same bundle.
interface id_branch_resolver_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int PC_W   = 32,
    parameter int OFFS_W = 16,
    parameter int CNT_W  = 16
);
    // ID-stage instruction
    logic              valid;
    logic [2:0]        branch_op;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [PC_W-1:0]   pc_plus_4;
    logic [OFFS_W-1:0] offset;

    // Downstream pipeline state used for hazard detection and forwarding
    logic [REG_AW-1:0] id_ex_rd;
    logic              id_ex_reg_write;
    logic              id_ex_mem_read;
    logic [REG_AW-1:0] ex_m_rd;
    logic              ex_m_reg_write;
    logic              ex_m_mem_read;
    logic [DATA_W-1:0] ex_m_alu_result;
    logic [REG_AW-1:0] m_wb_rd;
    logic              m_wb_reg_write;
    logic [DATA_W-1:0] m_wb_data;

    // Resolver outputs
    logic              stall;
    logic              flush_idex;
    logic              pc_src;
    logic [PC_W-1:0]   target;
    logic              flush_ifid;
    logic [CNT_W-1:0]  branch_count;
    logic [CNT_W-1:0]  taken_count;

    modport master (
        output valid, branch_op, rs, rt, rs_data, rt_data, pc_plus_4, offset,
               id_ex_rd, id_ex_reg_write, id_ex_mem_read,
               ex_m_rd, ex_m_reg_write, ex_m_mem_read, ex_m_alu_result,
               m_wb_rd, m_wb_reg_write, m_wb_data,
        input  stall, flush_idex, pc_src, target, flush_ifid,
               branch_count, taken_count
    );

    modport slave (
        input  valid, branch_op, rs, rt, rs_data, rt_data, pc_plus_4, offset,
               id_ex_rd, id_ex_reg_write, id_ex_mem_read,
               ex_m_rd, ex_m_reg_write, ex_m_mem_read, ex_m_alu_result,
               m_wb_rd, m_wb_reg_write, m_wb_data,
        output stall, flush_idex, pc_src, target, flush_ifid,
               branch_count, taken_count
    );
endinterface

// File: rtl/id_branch_resolver.sv
// ID-stage resolver for BEQ/BNE/BLEZ/BGTZ with EX/MEM and MEM/WB forwarding.
// Latency: redirect (pc_src/flush_ifid/target) one cycle after resolution.
// Backpressure: stalls 1 cycle on ALU-use / MEM-load hazards, 2 on EX-load.
// Ports: i_clk, i_reset (async active-low), bus (slave side of the bundle).
module id_branch_resolver #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int PC_W   = 32,
    parameter int OFFS_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    id_branch_resolver_if.slave   bus
);
    localparam logic [2:0] OP_BEQ  = 3'b001;
    localparam logic [2:0] OP_BNE  = 3'b010;
    localparam logic [2:0] OP_BLEZ = 3'b011;
    localparam logic [2:0] OP_BGTZ = 3'b100;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t            state;
    logic              pc_src_q;
    logic              flush_ifid_q;
    logic [PC_W-1:0]   target_q;
    logic [CNT_W-1:0]  branch_cnt_q;
    logic [CNT_W-1:0]  taken_cnt_q;

    logic              is_branch;
    logic              uses_rt;
    logic [1:0]        need_rs;
    logic [1:0]        need_rt;
    logic [1:0]        need;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              taken;
    logic              resolve;
    logic              stall;
    logic [PC_W-1:0]   offs_ext;
    logic [PC_W-1:0]   branch_target;

    // Bubbles needed before operand r is available to the branch comparator.
    // A load in EX needs two bubbles; an ALU op in EX or a load in MEM needs one.
    function automatic logic [1:0] hazard_need(
        input logic [REG_AW-1:0] r,
        input logic [REG_AW-1:0] ex_rd,
        input logic              ex_rw,
        input logic              ex_mr,
        input logic [REG_AW-1:0] mem_rd,
        input logic              mem_mr
    );
        logic [1:0] n;
        n = 2'd0;
        if (r != '0) begin
            if (ex_mr && ex_rd == r)
                n = 2'd2;
            else if ((ex_rw && ex_rd == r) || (mem_mr && mem_rd == r))
                n = 2'd1;
        end
        return n;
    endfunction

    // Youngest producer wins: EX/MEM ALU result, then MEM/WB, then regfile.
    function automatic logic [DATA_W-1:0] forward(
        input logic [REG_AW-1:0] r,
        input logic [DATA_W-1:0] rf_data,
        input logic [REG_AW-1:0] mem_rd,
        input logic              mem_rw,
        input logic              mem_mr,
        input logic [DATA_W-1:0] mem_data,
        input logic [REG_AW-1:0] wb_rd,
        input logic              wb_rw,
        input logic [DATA_W-1:0] wb_data
    );
        logic [DATA_W-1:0] d;
        d = rf_data;
        if (r != '0) begin
            if (mem_rw && !mem_mr && mem_rd == r)
                d = mem_data;
            else if (wb_rw && wb_rd == r)
                d = wb_data;
        end
        return d;
    endfunction

    always_comb begin
        is_branch = bus.valid && (bus.branch_op == OP_BEQ || bus.branch_op == OP_BNE ||
                                  bus.branch_op == OP_BLEZ || bus.branch_op == OP_BGTZ);
        uses_rt   = (bus.branch_op == OP_BEQ) || (bus.branch_op == OP_BNE);

        need_rs = hazard_need(bus.rs, bus.id_ex_rd, bus.id_ex_reg_write, bus.id_ex_mem_read,
                              bus.ex_m_rd, bus.ex_m_mem_read);
        need_rt = uses_rt ? hazard_need(bus.rt, bus.id_ex_rd, bus.id_ex_reg_write,
                                        bus.id_ex_mem_read, bus.ex_m_rd, bus.ex_m_mem_read)
                          : 2'd0;
        need    = !is_branch ? 2'd0 : ((need_rs > need_rt) ? need_rs : need_rt);

        op_a = forward(bus.rs, bus.rs_data, bus.ex_m_rd, bus.ex_m_reg_write, bus.ex_m_mem_read,
                       bus.ex_m_alu_result, bus.m_wb_rd, bus.m_wb_reg_write, bus.m_wb_data);
        op_b = forward(bus.rt, bus.rt_data, bus.ex_m_rd, bus.ex_m_reg_write, bus.ex_m_mem_read,
                       bus.ex_m_alu_result, bus.m_wb_rd, bus.m_wb_reg_write, bus.m_wb_data);

        // Signed compare against zero reduces to sign bit and zero test.
        taken = 1'b0;
        case (bus.branch_op)
            OP_BEQ:  taken = (op_a == op_b);
            OP_BNE:  taken = (op_a != op_b);
            OP_BLEZ: taken = op_a[DATA_W-1] || (op_a == '0);
            OP_BGTZ: taken = !op_a[DATA_W-1] && (op_a != '0);
            default: taken = 1'b0;
        endcase

        offs_ext      = {{(PC_W-OFFS_W){bus.offset[OFFS_W-1]}}, bus.offset};
        branch_target = bus.pc_plus_4 + (offs_ext << 2);

        resolve = is_branch && (state == S_IDLE) && (need == 2'd0);
        // Gated by reset so the stall drops the moment reset asserts,
        // even while a hazard is still presented on the inputs.
        stall   = i_reset && ((state == S_WAIT) || (need != 2'd0));
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state        <= S_IDLE;
            pc_src_q     <= 1'b0;
            flush_ifid_q <= 1'b0;
            target_q     <= '0;
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else begin
            case (state)
                S_IDLE:  if (need == 2'd2) state <= S_WAIT;
                S_WAIT:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            pc_src_q     <= resolve && taken;
            flush_ifid_q <= resolve && taken;
            if (resolve && taken)
                target_q <= branch_target;
            if (resolve) begin
                branch_cnt_q <= branch_cnt_q + CNT_W'(1);
                if (taken)
                    taken_cnt_q <= taken_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.stall        = stall;
    assign bus.flush_idex   = stall;
    assign bus.pc_src       = pc_src_q;
    assign bus.flush_ifid   = flush_ifid_q;
    assign bus.target       = target_q;
    assign bus.branch_count = branch_cnt_q;
    assign bus.taken_count  = taken_cnt_q;
endmodule

// File: tb/tb_id_branch_resolver.sv
// Directed bench for id_branch_resolver with an expected-result scoreboard.
// Each driven cycle pushes the expected registered outputs; they are popped
// and compared one clock later. Stall/flush_idex are checked combinationally.
module tb_id_branch_resolver;
    logic i_clk;
    logic i_reset;

    id_branch_resolver_if bus ();

    id_branch_resolver dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        pc_src;
        logic [31:0] target;
        logic [15:0] bc;
        logic [15:0] tc;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] m_tgt = 32'h0;
    logic [15:0] m_bc  = 16'h0;
    logic [15:0] m_tc  = 16'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        bus.valid = 0; bus.branch_op = 3'd0; bus.rs = 5'd0; bus.rt = 5'd0;
        bus.rs_data = 32'd0; bus.rt_data = 32'd0; bus.pc_plus_4 = 32'd0; bus.offset = 16'd0;
        bus.id_ex_rd = 5'd0; bus.id_ex_reg_write = 0; bus.id_ex_mem_read = 0;
        bus.ex_m_rd = 5'd0; bus.ex_m_reg_write = 0; bus.ex_m_mem_read = 0; bus.ex_m_alu_result = 32'd0;
        bus.m_wb_rd = 5'd0; bus.m_wb_reg_write = 0; bus.m_wb_data = 32'd0;
    endtask

    task automatic br(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [31:0] rsd, input logic [31:0] rtd,
                      input logic [31:0] pc4, input logic [15:0] off);
        bus.valid = 1; bus.branch_op = op; bus.rs = rs; bus.rt = rt;
        bus.rs_data = rsd; bus.rt_data = rtd; bus.pc_plus_4 = pc4; bus.offset = off;
    endtask

    // Called just after inputs are driven (1 time unit after a rising edge).
    task automatic cycle(input string tag, input bit exp_stall, input bit res,
                         input bit tk, input logic [31:0] tgt);
        exp_t e;
        #1;
        check({tag, "/stall"}, 32'(bus.stall), 32'(exp_stall));
        check({tag, "/flush_idex"}, 32'(bus.flush_idex), 32'(exp_stall));
        if (res) begin
            m_bc++;
            if (tk) begin
                m_tc++;
                m_tgt = tgt;
            end
        end
        e.pc_src = res && tk;
        e.target = m_tgt;
        e.bc     = m_bc;
        e.tc     = m_tc;
        sb.push_back(e);
        @(posedge i_clk);
        #1;
        e = sb.pop_front();
        check({tag, "/pc_src"}, 32'(bus.pc_src), 32'(e.pc_src));
        check({tag, "/flush_ifid"}, 32'(bus.flush_ifid), 32'(e.pc_src));
        check({tag, "/target"}, bus.target, e.target);
        check({tag, "/branch_count"}, 32'(bus.branch_count), 32'(e.bc));
        check({tag, "/taken_count"}, 32'(bus.taken_count), 32'(e.tc));
    endtask

    localparam logic [2:0] BEQ = 3'd1, BNE = 3'd2, BLEZ = 3'd3, BGTZ = 3'd4;

    initial begin
        clr();
        i_reset = 1'b0;
        // Hazard presented during reset must not stall.
        br(BNE, 5'd3, 5'd0, 32'd0, 32'd0, 32'h200, 16'h0010);
        bus.id_ex_rd = 5'd3; bus.id_ex_mem_read = 1;
        repeat (2) @(posedge i_clk);
        #1;
        check("rst/stall", 32'(bus.stall), 32'd0);
        check("rst/pc_src", 32'(bus.pc_src), 32'd0);
        check("rst/flush_ifid", 32'(bus.flush_ifid), 32'd0);
        check("rst/target", bus.target, 32'd0);
        check("rst/branch_count", 32'(bus.branch_count), 32'd0);
        check("rst/taken_count", 32'(bus.taken_count), 32'd0);
        clr();
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;

        // Plain BEQ, no hazard
        br(BEQ, 5'd1, 5'd2, 32'd5, 32'd5, 32'h100, 16'h0004);
        cycle("beq", 0, 1, 1, 32'h110);

        // Load-use: lw r3 in EX, then BNE r3,r0
        br(BNE, 5'd3, 5'd0, 32'd0, 32'd0, 32'h200, 16'h0010);
        bus.id_ex_rd = 5'd3; bus.id_ex_reg_write = 1; bus.id_ex_mem_read = 1;
        cycle("ld_use0", 1, 0, 0, 32'h0);
        bus.id_ex_rd = 5'd0; bus.id_ex_reg_write = 0; bus.id_ex_mem_read = 0;
        bus.ex_m_rd = 5'd3; bus.ex_m_reg_write = 1; bus.ex_m_mem_read = 1;
        cycle("ld_use1", 1, 0, 0, 32'h0);
        bus.ex_m_mem_read = 0; bus.ex_m_alu_result = 32'd7;
        cycle("ld_use2", 0, 1, 1, 32'h240);

        // ALU-use: add r4 in EX, then BEQ r4,r5; EX/MEM beats MEM/WB
        clr();
        br(BEQ, 5'd4, 5'd5, 32'd0, 32'd9, 32'h300, 16'hFFFF);
        bus.id_ex_rd = 5'd4; bus.id_ex_reg_write = 1;
        cycle("alu_use0", 1, 0, 0, 32'h0);
        bus.id_ex_rd = 5'd0; bus.id_ex_reg_write = 0;
        bus.ex_m_rd = 5'd4; bus.ex_m_reg_write = 1; bus.ex_m_alu_result = 32'd9;
        bus.m_wb_rd = 5'd4; bus.m_wb_reg_write = 1; bus.m_wb_data = 32'd3;
        cycle("alu_use1", 0, 1, 1, 32'h2FC);

        // MEM/WB-only forwarding: r6 from WB = 1 vs r0 -> BNE taken
        clr();
        br(BNE, 5'd6, 5'd0, 32'd0, 32'd0, 32'h700, 16'h0000);
        bus.m_wb_rd = 5'd6; bus.m_wb_reg_write = 1; bus.m_wb_data = 32'd1;
        cycle("wb_fwd", 0, 1, 1, 32'h700);

        // Back-to-back BLEZ/BGTZ resolutions
        clr();
        br(BLEZ, 5'd8, 5'd0, 32'h80000000, 32'd0, 32'h400, 16'h0001);
        cycle("blez_neg", 0, 1, 1, 32'h404);
        br(BGTZ, 5'd8, 5'd0, 32'h80000000, 32'd0, 32'h480, 16'h0001);
        cycle("bgtz_neg", 0, 1, 0, 32'h0);
        br(BLEZ, 5'd8, 5'd0, 32'd0, 32'd0, 32'h500, 16'h0002);
        cycle("blez_zero", 0, 1, 1, 32'h508);
        br(BGTZ, 5'd8, 5'd0, 32'd1, 32'd0, 32'h600, 16'h0003);
        cycle("bgtz_one", 0, 1, 1, 32'h60C);
        // BGTZ ignores rt even when rt has a load hazard
        bus.id_ex_rd = 5'd9; bus.id_ex_mem_read = 1; bus.rt = 5'd9;
        cycle("bgtz_rt_ign", 0, 1, 1, 32'h60C);

        // Negative offset wrap
        clr();
        br(BEQ, 5'd1, 5'd2, 32'd1, 32'd1, 32'h00010000, 16'h8000);
        cycle("neg_off", 0, 1, 1, 32'hFFFF0000);

        // Register 0 never hazards
        br(BEQ, 5'd0, 5'd0, 32'd0, 32'd0, 32'h900, 16'h0001);
        bus.id_ex_rd = 5'd0; bus.id_ex_mem_read = 1; bus.id_ex_reg_write = 1;
        cycle("r0_nohaz", 0, 1, 1, 32'h904);

        // Non-branch / invalid / reserved op with a hazard present
        clr();
        bus.id_ex_rd = 5'd3; bus.id_ex_mem_read = 1;
        br(3'd0, 5'd3, 5'd3, 32'd0, 32'd0, 32'hA00, 16'h0001);
        cycle("nonbranch", 0, 0, 0, 32'h0);
        br(BEQ, 5'd3, 5'd3, 32'd0, 32'd0, 32'hA00, 16'h0001);
        bus.valid = 0;
        cycle("invalid", 0, 0, 0, 32'h0);
        br(3'd5, 5'd3, 5'd3, 32'd0, 32'd0, 32'hA00, 16'h0001);
        cycle("reserved_op", 0, 0, 0, 32'h0);

        // Reset asserted mid-WAIT
        clr();
        br(BNE, 5'd3, 5'd0, 32'd0, 32'd0, 32'hB00, 16'h0001);
        bus.id_ex_rd = 5'd3; bus.id_ex_mem_read = 1;
        cycle("wait_entry", 1, 0, 0, 32'h0);
        clr();
        #1;
        check("wait/stall", 32'(bus.stall), 32'd1);
        i_reset = 1'b0;
        #1;
        check("wait_rst/stall", 32'(bus.stall), 32'd0);
        check("wait_rst/flush_idex", 32'(bus.flush_idex), 32'd0);
        check("wait_rst/branch_count", 32'(bus.branch_count), 32'd0);
        check("wait_rst/taken_count", 32'(bus.taken_count), 32'd0);
        check("wait_rst/target", bus.target, 32'd0);
        m_bc = 16'h0; m_tc = 16'h0; m_tgt = 32'h0;
        sb.delete();
        @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;
        br(BEQ, 5'd1, 5'd2, 32'd4, 32'd4, 32'h800, 16'h0008);
        cycle("post_rst", 0, 1, 1, 32'h820);
        clr();
        cycle("idle_after", 0, 0, 0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
